// File: rtl/xpb_lut_accum.sv
// xpb_lut_accum
//   Multi-segment table-lookup reduction accumulator for the modular-squaring
//   datapath. The upper product bits arrive as NSEG index segments of SEG_W
//   bits. Each segment indexes its own runtime-loadable table of
//   x*2^k mod N constants. The NSEG lookups are summed one per cycle into an
//   ACC_W-bit result. No modular reduction is done here.
//
//   Optional feature macro: XPB_ZERO_SKIP_EN
//     defined   : ACCUM visits only the nonzero segments, in ascending order.
//                 An all-zero input goes straight from IDLE to DONE.
//     undefined : ACCUM always lasts exactly NSEG cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (state, acc, cnt, seg_reg only)
//   tbl_we     table write strobe; tbl_seg / tbl_idx / tbl_wdata select the
//              table, the entry and the value. Writes to entry 0 are ignored.
//   in_valid   in_data is valid
//   in_ready   block can accept an input (IDLE only)
//   in_data    segment s is in_data[s*SEG_W +: SEG_W]
//   out_valid  out_data holds a finished sum (DONE only)
//   out_ready  downstream accepts the result
//   out_data   sum of the NSEG lookups, zero-extended to ACC_W
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid=1 and ready=0.
// in_ready and out_valid are never high together, so transactions never
// overlap.

module xpb_lut_accum #(
    parameter int SEG_W  = 5,
    parameter int NSEG   = 8,
    parameter int DATA_W = 1024,
    localparam int ACC_W = DATA_W + $clog2(NSEG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tbl_we,
    input  logic [$clog2(NSEG)-1:0] tbl_seg,
    input  logic [SEG_W-1:0]       tbl_idx,
    input  logic [DATA_W-1:0]      tbl_wdata,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NSEG*SEG_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data
);

    localparam int CW   = $clog2(NSEG);
    localparam int IN_W = NSEG * SEG_W;
    localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     cnt;
    logic [IN_W-1:0]   seg_reg;

    // Table storage is sized to a power of two so any tbl_seg value is a
    // legal address; tables beyond NSEG-1 are simply never read.
    logic [DATA_W-1:0] tbl [2**CW][2**SEG_W];

    logic [SEG_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_val;

    // Entry 0 reads as zero regardless of what the storage holds.
    always_comb begin
        rd_idx = seg_reg[int'(cnt)*SEG_W +: SEG_W];
        rd_val = '0;
        if (rd_idx != '0)
            rd_val = tbl[cnt][rd_idx];
    end

    // Table flops are not reset. The non-blocking write means a read in the
    // same cycle still sees the old contents.
    always_ff @(posedge clk) begin
        if (tbl_we && (tbl_idx != '0))
            tbl[tbl_seg][tbl_idx] <= tbl_wdata;
    end

`ifdef XPB_ZERO_SKIP_EN
    // Lowest segment at or above 'from' with a nonzero index.
    // Returns {found, segment}.
    function automatic logic [CW:0] next_nz(input logic [IN_W-1:0] d,
                                            input int from);
        logic [CW:0] r;
        r = '0;
        for (int s = NSEG - 1; s >= 0; s--) begin
            if ((s >= from) && (d[s*SEG_W +: SEG_W] != '0))
                r = {1'b1, CW'(s)};
        end
        return r;
    endfunction

    logic [CW:0] first_nz;
    logic [CW:0] later_nz;

    always_comb begin
        first_nz = next_nz(in_data, 0);
        later_nz = next_nz(seg_reg, int'(cnt) + 1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            seg_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        seg_reg <= in_data;
                        acc     <= '0;
`ifdef XPB_ZERO_SKIP_EN
                        if (first_nz[CW]) begin
                            cnt   <= first_nz[CW-1:0];
                            state <= ACCUM;
                        end else begin
                            cnt   <= '0;
                            state <= DONE;
                        end
`else
                        cnt   <= '0;
                        state <= ACCUM;
`endif
                    end
                end
                ACCUM: begin
                    acc <= acc + {{(ACC_W-DATA_W){1'b0}}, rd_val};
`ifdef XPB_ZERO_SKIP_EN
                    if (later_nz[CW])
                        cnt <= later_nz[CW-1:0];
                    else
                        state <= DONE;
`else
                    if (cnt == LAST)
                        state <= DONE;
                    else
                        cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;

endmodule

// File: tb/tb_xpb_lut_accum.sv
module tb_xpb_lut_accum;

    localparam int SEG_W  = 5;
    localparam int NSEG   = 8;
    localparam int DATA_W = 1024;
    localparam int ACC_W  = DATA_W + $clog2(NSEG);
    localparam int CW     = $clog2(NSEG);
    localparam int IN_W   = NSEG * SEG_W;
    localparam int NENT   = 1 << SEG_W;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              tbl_we;
    logic [CW-1:0]     tbl_seg;
    logic [SEG_W-1:0]  tbl_idx;
    logic [DATA_W-1:0] tbl_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    always #5 clk = ~clk;

    xpb_lut_accum #(.SEG_W(SEG_W), .NSEG(NSEG), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .tbl_we(tbl_we), .tbl_seg(tbl_seg), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [ACC_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] mdl [NSEG][NENT];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [ACC_W-1:0] model_sum(input logic [IN_W-1:0] d);
        logic [ACC_W-1:0] sum;
        logic [SEG_W-1:0] idx;
        sum = '0;
        for (int s = 0; s < NSEG; s++) begin
            idx = d[s*SEG_W +: SEG_W];
            if (idx != '0)
                sum = sum + {{(ACC_W-DATA_W){1'b0}}, mdl[s][idx]};
        end
        return sum;
    endfunction

    // Edges between acceptance and the first out_valid sample.
    function automatic int exp_lat(input logic [IN_W-1:0] d);
`ifdef XPB_ZERO_SKIP_EN
        int n;
        n = 0;
        for (int s = 0; s < NSEG; s++)
            if (d[s*SEG_W +: SEG_W] != '0) n++;
        return n;
`else
        return NSEG;
`endif
    endfunction

    function automatic logic [IN_W-1:0] rand_data();
        logic [IN_W-1:0] d;
        d = '0;
        for (int s = 0; s < NSEG; s++)
            if ($urandom_range(0, 1) == 1)
                d[s*SEG_W +: SEG_W] = SEG_W'($urandom_range(1, NENT - 1));
        return d;
    endfunction

    // ---------------- driver tasks (all driving #1 after posedge) ----------------
    task automatic tbl_wr(input int seg, input int idx, input logic [DATA_W-1:0] val);
        tbl_we    = 1'b1;
        tbl_seg   = CW'(seg);
        tbl_idx   = SEG_W'(idx);
        tbl_wdata = val;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        if (idx != 0) mdl[seg][idx] = val;
    endtask

    task automatic load_tables(input bit all_ones);
        for (int s = 0; s < NSEG; s++)
            for (int i = 1; i < NENT; i++)
                tbl_wr(s, i, all_ones ? {DATA_W{1'b1}} : DATA_W'(s * 32 + i + 1));
    endtask

    task automatic send(input logic [IN_W-1:0] d);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got_lo=%h exp=0", out_data[63:0]); end
    endtask

    task automatic test_single();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] e;
        int lat;
        load_tables(1'b0);
        d = '0;
        d[2*SEG_W +: SEG_W] = 5'd5;
        exp_q.push_back(ACC_W'(70));
        send(d);
        wait_out(lat);
        n_cmp++;
`ifdef XPB_ZERO_SKIP_EN
        if (lat !== 1) begin n_err++; $display("FAIL single_latency got=%0d exp=1", lat); end
`else
        if (lat !== NSEG) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", lat, NSEG); end
`endif
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e) begin n_err++; $display("FAIL single_data got_lo=%h exp_lo=%h", out_data[63:0], e[63:0]); end
        release_out();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_collision();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] e;
        int lat;
        d = '0;
        d[0*SEG_W +: SEG_W] = 5'd3;
        d[1*SEG_W +: SEG_W] = 5'd7;
        // Old contents: tbl[0][3]=4, tbl[1][7]=40.
        exp_q.push_back(model_sum(d));
        send(d);
        @(posedge clk); #1;          // cycle in which tbl[1][7] is read
        tbl_wr(1, 7, DATA_W'(1000));
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e || e !== ACC_W'(44)) begin n_err++; $display("FAIL collision_old got_lo=%h exp_lo=%h", out_data[63:0], e[63:0]); end
        release_out();
        exp_q.push_back(model_sum(d));
        send(d);
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e || e !== ACC_W'(1004)) begin n_err++; $display("FAIL collision_new got_lo=%h exp_lo=%h", out_data[63:0], e[63:0]); end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] e;
        int lat;
        d = '0;
        for (int s = 0; s < NSEG; s++) d[s*SEG_W +: SEG_W] = SEG_W'($urandom_range(1, NENT - 1));
        send(d);                      // now in 1st ACCUM cycle
        @(posedge clk); #1;           // 2nd
        @(posedge clk); #1;           // 3rd
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL midreset_out_data got_lo=%h exp=0", out_data[63:0]); end
        @(posedge clk); #1;
        reset = 1'b0;
        d = rand_data();
        exp_q.push_back(model_sum(d));
        send(d);
        wait_out(lat);
        n_cmp++;
        if (lat !== exp_lat(d)) begin n_err++; $display("FAIL midreset_next_latency got=%0d exp=%0d", lat, exp_lat(d)); end
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e) begin n_err++; $display("FAIL midreset_next_data got_lo=%h exp_lo=%h", out_data[63:0], e[63:0]); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] e;
        int lat;
        for (int t = 0; t < 6; t++) begin
            d = rand_data();
            exp_q.push_back(model_sum(d));
            send(d);
            wait_out(lat);
            n_cmp++;
            if (lat !== exp_lat(d)) begin n_err++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", t, lat, exp_lat(d)); end
            e = exp_q.pop_front();
            n_cmp++;
            if (out_data !== e) begin n_err++; $display("FAIL b2b_data[%0d] got_lo=%h exp_lo=%h", t, out_data[63:0], e[63:0]); end
            release_out();
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", t, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] e;
        int lat;
        int bad_data;
        int bad_rdy;
        d = '0;
        for (int s = 0; s < NSEG; s++) d[s*SEG_W +: SEG_W] = SEG_W'(s + 3);
        exp_q.push_back(model_sum(d));
        send(d);
        wait_out(lat);
        e = exp_q.pop_front();
        in_valid = 1'b1;              // must be ignored while DONE
        in_data  = rand_data();
        bad_data = 0;
        bad_rdy  = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_data !== e || out_valid !== 1'b1) begin
                n_err++; bad_data++;
                if (bad_data == 1) $display("FAIL bp_hold[%0d] got_lo=%h valid=%b exp_lo=%h valid=1", c, out_data[63:0], out_valid, e[63:0]);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++; bad_rdy++;
                if (bad_rdy == 1) $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready);
            end
        end
        in_valid = 1'b0;
        release_out();
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_no_accept got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_zero();
        logic [ACC_W-1:0] e;
        int lat;
        for (int s = 0; s < NSEG; s++) tbl_wr(s, 0, {DATA_W{1'b1}});
        exp_q.push_back(model_sum('0));
        send('0);
        wait_out(lat);
        n_cmp++;
`ifdef XPB_ZERO_SKIP_EN
        if (lat !== 0) begin n_err++; $display("FAIL zero_latency got=%0d exp=0", lat); end
`else
        if (lat !== NSEG) begin n_err++; $display("FAIL zero_latency got=%0d exp=%0d", lat, NSEG); end
`endif
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e || e !== '0) begin n_err++; $display("FAIL zero_data got_lo=%h exp=0", out_data[63:0]); end
        release_out();
    endtask

    task automatic test_full_carry();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] e;
        logic [ACC_W-1:0] ref_v;
        int lat;
        load_tables(1'b1);
        d = '1;
        // 8*(2^1024-1) = 2^1027 - 8
        ref_v = '1;
        ref_v[2:0] = 3'b000;
        exp_q.push_back(model_sum(d));
        send(d);
        wait_out(lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e || e !== ref_v) begin n_err++; $display("FAIL full_data got_hi=%h got_lo=%h exp_hi=%h exp_lo=%h", out_data[ACC_W-1 -: 16], out_data[63:0], ref_v[ACC_W-1 -: 16], ref_v[63:0]); end
        n_cmp++;
        if (out_data[ACC_W-1 -: 3] !== 3'b111) begin n_err++; $display("FAIL full_top_bits got=%b exp=111", out_data[ACC_W-1 -: 3]); end
        release_out();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        reset     = 1'b1;
        tbl_we    = 1'b0;
        tbl_seg   = '0;
        tbl_idx   = '0;
        tbl_wdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int s = 0; s < NSEG; s++)
            for (int i = 0; i < NENT; i++)
                mdl[s][i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_single();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        test_backpressure();
        test_zero();
        test_full_carry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
